// File: rtl/pc_pkg.sv
// Shared types, constants and helpers for the fetch PC generator.
package pc_pkg;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hbfc0_0000;

  typedef enum logic {PC_RUN, PC_HOLD} pc_state_t;

  typedef enum logic [1:0] {RD_NONE, RD_BRANCH, RD_EXC} redirect_kind_t;

  // Instruction slots left between addr and the next fetch-group boundary.
  function automatic logic [31:0] slots_to_boundary(input logic [31:0] addr,
                                                    input int fetch_width);
    logic [31:0] offset;
    offset = (addr >> 2) & (32'(fetch_width) - 32'd1);
    return 32'(fetch_width) - offset;
  endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds one redirect that arrived while the front end was stalled.
// Exceptions always overwrite; branches only fill an empty slot.
module pc_redirect_latch
  import pc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           pc_en,
  input  logic           branch_taken,
  input  logic [31:0]    branch_address,
  input  logic           exception_taken,
  input  logic [31:0]    exception_address,
  output redirect_kind_t pending_kind,
  output logic [31:0]    pending_address
);

  redirect_kind_t kind_reg;
  logic [31:0]    addr_reg;

  // A branch seen behind an already-latched redirect is on the wrong path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_reg <= RD_NONE;
      addr_reg <= '0;
    end else if (pc_en) begin
      kind_reg <= RD_NONE;
    end else if (exception_taken) begin
      kind_reg <= RD_EXC;
      addr_reg <= exception_address;
    end else if (branch_taken && kind_reg == RD_NONE) begin
      kind_reg <= RD_BRANCH;
      addr_reg <= branch_address;
    end
  end

  assign pending_kind    = kind_reg;
  assign pending_address = addr_reg;

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch-group PC generator: redirect priority, stall capture and
// boundary-clamped sequential advance.
module pc_fetch_gen
  import pc_pkg::*;
#(
  parameter int          FETCH_WIDTH  = 2,
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter int          CW           = $clog2(FETCH_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_en,
  input  logic          fifo_full,
  input  logic [CW-1:0] fetch_count,
  input  logic          branch_taken,
  input  logic [31:0]   branch_address,
  input  logic          exception_taken,
  input  logic [31:0]   exception_address,
  output logic [31:0]   pc_address,
  output logic          pc_valid,
  output logic [CW-1:0] group_slots,
  output logic          redirect_pending,
  output logic          misalign
);

  pc_state_t      state_reg, state_next;
  logic [31:0]    pc_reg, pc_next;
  logic           valid_reg;
  logic           misalign_reg;
  logic [CW-1:0]  take;
  redirect_kind_t pending_kind;
  logic [31:0]    pending_address;

  pc_redirect_latch u_latch (
    .clk               (clk),
    .rst               (rst),
    .pc_en             (pc_en),
    .branch_taken      (branch_taken),
    .branch_address    (branch_address),
    .exception_taken   (exception_taken),
    .exception_address (exception_address),
    .pending_kind      (pending_kind),
    .pending_address   (pending_address)
  );

  assign group_slots = CW'(slots_to_boundary(pc_reg, FETCH_WIDTH));
  assign take        = (fetch_count > group_slots) ? group_slots : fetch_count;

  // Slots are only consumed from a valid request, so an invalid PC
  // (just out of reset, or misaligned) never advances on its own.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (pc_en) begin
      state_next = PC_RUN;
      if (exception_taken) begin
        pc_next = exception_address;
      end else if (state_reg == PC_HOLD && pending_kind != RD_NONE) begin
        pc_next = pending_address;
      end else if (branch_taken) begin
        pc_next = branch_address;
      end else if (valid_reg && !fifo_full && fetch_count != '0) begin
        pc_next = pc_reg + (32'(take) << 2);
      end
    end else begin
      state_next = PC_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= PC_RUN;
      pc_reg       <= RESET_VECTOR;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      valid_reg    <= (pc_next[1:0] == 2'b00);
      misalign_reg <= (pc_next[1:0] != 2'b00);
    end
  end

  assign pc_address       = pc_reg;
  assign pc_valid         = valid_reg;
  assign misalign         = misalign_reg;
  assign redirect_pending = (pending_kind != RD_NONE);

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Checks two widths of pc_fetch_gen (4 and 2 slots) side by side against
// an arithmetic reference model, with directed scenarios then random traffic.
module tb_pc_fetch_gen;

  localparam logic [31:0] RV = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_en = 1'b0, fifo_full = 1'b0;
  logic [2:0]  fc4 = '0;
  logic [1:0]  fc2 = '0;
  logic        branch_taken = 1'b0, exception_taken = 1'b0;
  logic [31:0] branch_address = '0, exception_address = '0;

  logic [31:0] pc4, pc2;
  logic        valid4, valid2, pend4, pend2, mis4, mis2;
  logic [2:0]  gs4;
  logic [1:0]  gs2;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          fw [2] = '{4, 2};
  logic [31:0] m_pc [2];
  logic        m_valid [2];
  logic        m_mis [2];
  logic        m_pend_v;
  logic [31:0] m_pend_addr;

  always #5 clk = ~clk;

  pc_fetch_gen #(.FETCH_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .pc_en(pc_en), .fifo_full(fifo_full), .fetch_count(fc4),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .exception_taken(exception_taken), .exception_address(exception_address),
    .pc_address(pc4), .pc_valid(valid4), .group_slots(gs4),
    .redirect_pending(pend4), .misalign(mis4)
  );

  pc_fetch_gen #(.FETCH_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .pc_en(pc_en), .fifo_full(fifo_full), .fetch_count(fc2),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .exception_taken(exception_taken), .exception_address(exception_address),
    .pc_address(pc2), .pc_valid(valid2), .group_slots(gs2),
    .redirect_pending(pend2), .misalign(mis2)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]    = RV;
      m_valid[k] = 1'b0;
      m_mis[k]   = 1'b0;
    end
    m_pend_v    = 1'b0;
    m_pend_addr = '0;
  endtask

  function automatic int slots_left(input logic [31:0] pc, input int w);
    return w - int'((pc / 4) % 32'(w));
  endfunction

  // One rising edge of the architectural behaviour, using the inputs now driven.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n;
      int s;
      n = (k == 0) ? int'(fc4) : int'(fc2);
      s = slots_left(m_pc[k], fw[k]);
      if (pc_en) begin
        if (exception_taken)     m_pc[k] = exception_address;
        else if (m_pend_v)       m_pc[k] = m_pend_addr;
        else if (branch_taken)   m_pc[k] = branch_address;
        else if (m_valid[k] && !fifo_full && n > 0)
          m_pc[k] = m_pc[k] + 32'(4 * ((n < s) ? n : s));
      end
      m_valid[k] = (m_pc[k] % 4 == 0);
      m_mis[k]   = !m_valid[k];
    end
    if (pc_en) begin
      m_pend_v = 1'b0;
    end else if (exception_taken) begin
      m_pend_v    = 1'b1;
      m_pend_addr = exception_address;
    end else if (branch_taken && !m_pend_v) begin
      m_pend_v    = 1'b1;
      m_pend_addr = branch_address;
    end
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (pc4 === m_pc[0]) else begin
      errors++; $error("FAIL %s pc4 got %h exp %h", tag, pc4, m_pc[0]); end
    checks++;
    assert (pc2 === m_pc[1]) else begin
      errors++; $error("FAIL %s pc2 got %h exp %h", tag, pc2, m_pc[1]); end
    checks++;
    assert (valid4 === m_valid[0]) else begin
      errors++; $error("FAIL %s valid4 got %b exp %b", tag, valid4, m_valid[0]); end
    checks++;
    assert (valid2 === m_valid[1]) else begin
      errors++; $error("FAIL %s valid2 got %b exp %b", tag, valid2, m_valid[1]); end
    checks++;
    assert (mis4 === m_mis[0]) else begin
      errors++; $error("FAIL %s mis4 got %b exp %b", tag, mis4, m_mis[0]); end
    checks++;
    assert (mis2 === m_mis[1]) else begin
      errors++; $error("FAIL %s mis2 got %b exp %b", tag, mis2, m_mis[1]); end
    checks++;
    assert (gs4 === 3'(slots_left(m_pc[0], 4))) else begin
      errors++; $error("FAIL %s slots4 got %0d exp %0d", tag, gs4, slots_left(m_pc[0], 4)); end
    checks++;
    assert (gs2 === 2'(slots_left(m_pc[1], 2))) else begin
      errors++; $error("FAIL %s slots2 got %0d exp %0d", tag, gs2, slots_left(m_pc[1], 2)); end
    checks++;
    assert (pend4 === m_pend_v) else begin
      errors++; $error("FAIL %s pend4 got %b exp %b", tag, pend4, m_pend_v); end
    checks++;
    assert (pend2 === m_pend_v) else begin
      errors++; $error("FAIL %s pend2 got %b exp %b", tag, pend2, m_pend_v); end
  endtask

  task automatic step(input bit en, input bit ff, input int fc,
                      input bit bt, input logic [31:0] ba,
                      input bit et, input logic [31:0] ea, input string tag);
    pc_en             = en;
    fifo_full         = ff;
    fc4               = 3'((fc > 4) ? 4 : fc);
    fc2               = 2'((fc > 2) ? 2 : fc);
    branch_taken      = bt;
    branch_address    = ba;
    exception_taken   = et;
    exception_address = ea;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    $display("%-10s en=%0d ff=%0d fc=%0d bt=%0d et=%0d -> pc4=%h pc2=%h pend=%0d mis=%0d%0d",
             tag, en, ff, fc, bt, et, pc4, pc2, pend4, mis4, mis2);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return 32'hffff_fff0 | (r & 32'h0000_000c);
      1:       return r;
      default: return r & 32'hffff_fffc;
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    rst = 1'b1;
    step(1, 0, 4, 0, 0, 0, 0, "first");
    step(1, 0, 4, 0, 0, 0, 0, "adv1");
    step(1, 0, 4, 0, 0, 0, 0, "adv2");

    // group boundary clamp and fifo hold
    step(1, 0, 0, 1, 32'hbfc0_0008, 0, 0, "br_b008");
    step(1, 0, 4, 0, 0, 0, 0, "clamp");
    step(1, 1, 2, 0, 0, 0, 0, "fifofull");

    // stalled branch held for three cycles
    step(0, 0, 0, 1, 32'h8000_1000, 0, 0, "stall_br");
    step(0, 0, 2, 0, 0, 0, 0, "stall2");
    step(0, 0, 2, 0, 0, 0, 0, "stall3");
    step(1, 1, 0, 0, 0, 0, 0, "release");

    // pending override orderings
    step(0, 0, 0, 1, 32'h8000_1000, 0, 0, "ovr_br");
    step(0, 0, 0, 0, 0, 1, 32'hbfc0_0380, "ovr_exc");
    step(1, 0, 0, 0, 0, 0, 0, "ovr_rel");
    step(0, 0, 0, 0, 0, 1, 32'hbfc0_0380, "rev_exc");
    step(0, 0, 0, 1, 32'h8000_1000, 0, 0, "rev_br");
    step(1, 0, 0, 0, 0, 0, 0, "rev_rel");
    step(1, 0, 2, 1, 32'h8000_2000, 1, 32'hbfc0_0380, "both");
    step(0, 0, 0, 1, 32'h8000_3000, 0, 0, "hold_br");
    step(1, 0, 0, 1, 32'h8000_4000, 0, 0, "rel_ignbr");

    // wrap and misalign
    step(1, 0, 0, 1, 32'hffff_fff8, 0, 0, "to_fff8");
    step(1, 0, 2, 0, 0, 0, 0, "wrap");
    step(1, 0, 0, 1, 32'h8000_0002, 0, 0, "misal");
    step(1, 0, 2, 0, 0, 0, 0, "frozen1");
    step(1, 0, 2, 0, 0, 0, 0, "frozen2");
    step(1, 0, 2, 0, 0, 1, 32'hbfc0_0380, "mis_clr");

    // asynchronous reset while a redirect is pending
    step(0, 0, 0, 1, 32'h8000_1000, 0, 0, "pre_rst");
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    #2;
    rst = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, "post_rst");
    step(1, 0, 2, 0, 0, 0, 0, "post_adv");

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 4)),
           $urandom_range(0, 6) == 0, rand_addr(),
           $urandom_range(0, 11) == 0, rand_addr(), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
